// File: rtl/ps2_data_output.sv
// PS/2 host-to-device transmitter: inhibits the clock line, issues a request-to-send,
// shifts out start, 8 data bits (LSB first), odd parity and stop, then samples the ACK.
// Optional macro PS2_TX_TIMEOUT_EN adds a device-clock watchdog in the frame states.
module ps2_data_output #(
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_command,
    input  logic [7:0] command,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       ps2_tx_busy,
    output logic       ps2_command_sent,
    output logic       ps2_tx_error
);

    localparam int unsigned CntW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StInhibit = 3'd1,
        StRequest = 3'd2,
        StStart   = 3'd3,
        StData    = 3'd4,
        StParity  = 3'd5,
        StStop    = 3'd6
    } state_e;

    state_e         r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [3:0]     r_bit, w_bit_next;
    logic [7:0]     r_shift, w_shift_next;
    logic           r_parity, w_parity_next;
    logic           r_clk_oe, w_clk_oe_next;
    logic           r_data_oe, w_data_oe_next;
    logic           r_busy, w_busy_next;
    logic           r_sent, w_sent_next;
    logic           r_err, w_err_next;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WdW-1:0] r_wdog, w_wdog_next;
    logic           w_active;
`endif

    // Next-state, datapath and registered-output values; outputs track the next state.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = r_data_oe;
        w_sent_next    = 1'b0;
        w_err_next     = 1'b0;

        case (r_state)
            StIdle: begin
                w_data_oe_next = 1'b0;
                if (send_command) begin
                    w_shift_next  = command;
                    w_parity_next = ~^command;
                    w_cnt_next    = '0;
                    w_clk_oe_next = 1'b1;
                    w_state_next  = StInhibit;
                end
            end
            StInhibit: begin
                w_clk_oe_next  = 1'b1;
                w_data_oe_next = 1'b0;
                w_cnt_next     = r_cnt + CntW'(1);
                if (r_cnt == CntW'(INHIBIT_CYCLES - 1)) begin
                    w_data_oe_next = 1'b1;
                    w_state_next   = StRequest;
                end
            end
            StRequest: begin
                // Clock released while data stays low: the start bit is on the line.
                w_data_oe_next = 1'b1;
                w_state_next   = StStart;
            end
            StStart: begin
                w_data_oe_next = 1'b1;
                if (ps2_clk_negedge) begin
                    w_data_oe_next = ~r_shift[0];
                    w_bit_next     = 4'd1;
                    w_state_next   = StData;
                end
            end
            StData: begin
                if (ps2_clk_negedge) begin
                    if (r_bit < 4'd8) begin
                        w_data_oe_next = ~r_shift[r_bit[2:0]];
                        w_bit_next     = r_bit + 4'd1;
                    end else begin
                        w_data_oe_next = ~r_parity;
                        w_state_next   = StParity;
                    end
                end
            end
            StParity: begin
                if (ps2_clk_negedge) begin
                    w_data_oe_next = 1'b0;
                    w_state_next   = StStop;
                end
            end
            StStop: begin
                w_data_oe_next = 1'b0;
                if (ps2_clk_negedge) begin
                    // Device pulls data low to acknowledge.
                    w_sent_next  = ~ps2_data;
                    w_err_next   = ps2_data;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_data_oe_next = 1'b0;
                w_state_next   = StIdle;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        w_active = (r_state == StStart) || (r_state == StData) ||
                   (r_state == StParity) || (r_state == StStop);
        if (w_active && !ps2_clk_negedge && (r_wdog == WdW'(TIMEOUT_CYCLES - 1))) begin
            w_state_next   = StIdle;
            w_clk_oe_next  = 1'b0;
            w_data_oe_next = 1'b0;
            w_sent_next    = 1'b0;
            w_err_next     = 1'b1;
        end
        // Restart on every device edge and on every state entry.
        w_wdog_next = (w_active && !ps2_clk_negedge && (w_state_next == r_state)) ?
                      r_wdog + WdW'(1) : '0;
`endif

        w_busy_next = (w_state_next != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_clk_oe  <= w_clk_oe_next;
            r_data_oe <= w_data_oe_next;
            r_busy    <= w_busy_next;
            r_sent    <= w_sent_next;
            r_err     <= w_err_next;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end
`endif

    assign ps2_clk_oe       = r_clk_oe;
    assign ps2_data_oe      = r_data_oe;
    assign ps2_tx_busy      = r_busy;
    assign ps2_command_sent = r_sent;
    assign ps2_tx_error     = r_err;

endmodule

// File: doc/ps2_data_output.md
PS2_DATA_OUTPUT -- requirements
Module: ps2_data_output

Interface
REQ-001 Parameters: INHIBIT_CYCLES, default 1200, clock-inhibit length in clk cycles (100 us at 12 MHz); TIMEOUT_CYCLES, default 24000, device-clock watchdog length in clk cycles (2 ms at 12 MHz).
REQ-002 Port `clk`, input, 1 bit: the block's single clock; all logic is on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port `send_command`, input, 1 bit: request to transmit `command`.
REQ-005 Port `command`, input, 8 bits: byte to send host-to-device.
REQ-006 Port `ps2_clk_negedge`, input, 1 bit: single-cycle pulse on each synchronised falling edge of the PS/2 clock.
REQ-007 Port `ps2_data`, input, 1 bit: synchronised PS/2 data line level, used for ACK sampling.
REQ-008 Port `ps2_clk_oe`, output, 1 bit: 1 = pull the PS/2 clock line low; 0 = release it.
REQ-009 Port `ps2_data_oe`, output, 1 bit: 1 = pull the PS/2 data line low; 0 = release it.
REQ-010 Port `ps2_tx_busy`, output, 1 bit: high in every state except IDLE.
REQ-011 Port `ps2_command_sent`, output, 1 bit: one-cycle strobe; the device acknowledged the byte.
REQ-012 Port `ps2_tx_error`, output, 1 bit: one-cycle strobe; no ACK was received, or a timeout occurred.

Function
REQ-013 All outputs are registered.
REQ-014 FSM states: IDLE, INHIBIT, REQUEST, START, DATA, PARITY, STOP.
REQ-015 IDLE, with send_command=1: latch `command` into the shift register, latch parity = ~^command (odd parity), clear the counter, go to INHIBIT. send_command is ignored in every other state.
REQ-016 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0; the counter increments each cycle; at counter==INHIBIT_CYCLES-1, go to REQUEST.
REQ-017 REQUEST, exactly one cycle: ps2_clk_oe=1, ps2_data_oe=1; then go to START.
REQ-018 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0). On ps2_clk_negedge: ps2_data_oe=~bit0, bit counter=1, go to DATA.
REQ-019 DATA: on ps2_clk_negedge with bit counter<8, ps2_data_oe=~bit[counter] and the counter increments. With bit counter==8, ps2_data_oe=~parity and go to PARITY. Bit order is LSB first.
REQ-020 PARITY: on ps2_clk_negedge, ps2_data_oe=0 (stop bit 1 by release), go to STOP.
REQ-021 STOP: on ps2_clk_negedge, sample ps2_data. If 0, strobe ps2_command_sent; if 1, strobe ps2_tx_error. Either way go to IDLE.
REQ-022 Output timing: each ps2_data_oe change occurs on the clk edge after the ps2_clk_negedge pulse (latency 1). Strobes assert on the clk edge after the STOP-state negedge.
REQ-023 In IDLE, ps2_clk_oe=0 and ps2_data_oe=0. Both lines are released on the same cycle the FSM enters IDLE.
REQ-024 A ps2_clk_negedge during IDLE, INHIBIT or REQUEST is ignored.
REQ-025 ps2_command_sent and ps2_tx_error never assert in the same cycle.
REQ-026 Illegal state encodings go to IDLE on the next cycle with both lines released.

Reset
REQ-027 When rst_n=0 at a clk edge: state=IDLE, counters=0, shift register=0x00, all outputs=0.
REQ-028 Reset asserted mid-transfer releases both lines on that edge and produces no strobe.

Configuration
REQ-029 Macro PS2_TX_TIMEOUT_EN defined: in START, DATA, PARITY and STOP, a watchdog counts clk cycles since entering the state or since the last ps2_clk_negedge. At TIMEOUT_CYCLES-1 it releases both lines, strobes ps2_tx_error, and goes to IDLE.
REQ-030 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog logic exists, and the FSM waits indefinitely for device clock edges.

Verification
REQ-031 Scenario 1: send_command with command=0xF4, device clocks 11 falling edges, ps2_data=0 at the 11th -> data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; ps2_command_sent pulses once; busy drops.
REQ-032 Scenario 2: command=0xED, ps2_data=1 at the 11th edge -> parity bit 1 driven; ps2_tx_error pulses once; ps2_command_sent stays 0.
REQ-033 Scenario 3: after send_command -> ps2_clk_oe=1 for exactly 1200 cycles plus 1 REQUEST cycle with ps2_data_oe=1; then ps2_clk_oe=0 with ps2_data_oe still 1.
REQ-034 Scenario 4: second send_command with 0xAA while busy -> ignored; the 0xF4 frame completes unchanged.
REQ-035 Scenario 5: rst_n=0 after the 5th data bit -> both OE=0 on the same edge; no strobe; a subsequent send completes normally.
REQ-036 Scenario 6, PS2_TX_TIMEOUT_EN defined: device stops clocking after the start bit -> ps2_tx_error at 24000 cycles, lines released; with the macro undefined, busy stays high.
